// File: rtl/approx_adder_pkg.sv
// approx_adder_pkg: mode constants, parameter limits and approximate low-part sum helper
package approx_adder_pkg;
  localparam logic MODE_APPROX = 1'b0;
  localparam logic MODE_EXACT = 1'b1;
  localparam int MIN_WIDTH = 4;
  localparam int MIN_APPROX_BITS = 2;
  localparam int MIN_EXACT_BITS = 2;
  function automatic logic [32:0] approx_low_sum(input logic [31:0] a, input logic [31:0] b, input int unsigned n);
    logic [31:0] s;
    logic c;
    s = '0;
    c = 1'b0;
    for (int unsigned k = 0; k < n / 2; k++) begin
      s[2*k +: 2] = c ? (a[2*k +: 2] & b[2*k +: 2]) : ~(a[2*k +: 2] & b[2*k +: 2]);
      c = (&a[2*k +: 2]) | (&b[2*k +: 2]) | c;
    end
    return {c, s};
  endfunction
endpackage

// File: rtl/approx_blk2.sv
// approx_blk2: 2-bit approximate adder block (a, b, cin -> s, cout)
module approx_blk2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       cin,
  output logic [1:0] s,
  output logic       cout
);
  assign s = cin ? (a & b) : ~(a & b);
  assign cout = (&a) | (&b) | cin;
endmodule

// File: rtl/approx_adder_pipe.sv
// approx_adder_pipe: two-stage pipelined approximate/exact adder with valid/ready handshakes
// ports: clk, rst_n (synchronous, active-low); in_valid/in_ready/in_a/in_b/in_mode (0 approx, 1 exact)
// operand side; out_valid/out_ready/out_sum (MSB is carry-out) result side; ops_count saturating
// count of output transfers. Define APPROX_ERR_MON_EN to add err_abs and err_count outputs.
module approx_adder_pipe
  import approx_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int APPROX_BITS = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic [CNT_W-1:0] ops_count
`ifdef APPROX_ERR_MON_EN
  ,
  output logic [WIDTH:0]   err_abs,
  output logic [CNT_W-1:0] err_count
`endif
);
  localparam int HW = WIDTH - APPROX_BITS;
  localparam int NB = APPROX_BITS / 2;
  if (WIDTH < MIN_WIDTH || APPROX_BITS < MIN_APPROX_BITS || APPROX_BITS % 2 != 0 ||
      APPROX_BITS > WIDTH - MIN_EXACT_BITS) begin : g_bad_params
    $error("approx_adder_pipe: illegal WIDTH/APPROX_BITS combination");
  end
  logic [NB:0] c;
  logic [APPROX_BITS-1:0] lo_apx;
  logic [APPROX_BITS:0] lo_ex;
  logic s1_valid, s1_c, adv1, adv2;
  logic [APPROX_BITS-1:0] s1_lo;
  logic [HW-1:0] s1_ahi, s1_bhi;
  logic [HW:0] hi;
  logic [WIDTH:0] sum_nx;
  assign c[0] = 1'b0;
  for (genvar k = 0; k < NB; k++) begin : g_blk
    approx_blk2 u_blk (
      .a(in_a[2*k +: 2]),
      .b(in_b[2*k +: 2]),
      .cin(c[k]),
      .s(lo_apx[2*k +: 2]),
      .cout(c[k+1])
    );
  end
  assign lo_ex = {1'b0, in_a[APPROX_BITS-1:0]} + {1'b0, in_b[APPROX_BITS-1:0]};
  assign adv2 = !out_valid || out_ready;
  assign adv1 = !s1_valid || adv2;
  assign in_ready = adv1;
  assign hi = {1'b0, s1_ahi} + {1'b0, s1_bhi} + {{HW{1'b0}}, s1_c};
  assign sum_nx = {hi, s1_lo};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      out_valid <= 1'b0;
      out_sum <= '0;
      ops_count <= '0;
    end else begin
      if (adv1) s1_valid <= in_valid;
      if (in_valid && adv1) begin
        s1_lo <= (in_mode == MODE_EXACT) ? lo_ex[APPROX_BITS-1:0] : lo_apx;
        s1_c <= (in_mode == MODE_EXACT) ? lo_ex[APPROX_BITS] : c[NB];
        s1_ahi <= in_a[WIDTH-1:APPROX_BITS];
        s1_bhi <= in_b[WIDTH-1:APPROX_BITS];
      end
      if (adv2) out_valid <= s1_valid;
      if (s1_valid && adv2) out_sum <= sum_nx;
      if (out_valid && out_ready) ops_count <= ops_count + CNT_W'(ops_count != '1);
    end
  end
`ifdef APPROX_ERR_MON_EN
  logic [WIDTH:0] s1_ref, err_nx;
  assign err_nx = (sum_nx >= s1_ref) ? sum_nx - s1_ref : s1_ref - sum_nx;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_abs <= '0;
      err_count <= '0;
    end else begin
      if (in_valid && adv1) s1_ref <= {1'b0, in_a} + {1'b0, in_b};
      if (s1_valid && adv2) err_abs <= err_nx;
      if (out_valid && out_ready && err_abs != '0) err_count <= err_count + CNT_W'(err_count != '1);
    end
  end
`endif
endmodule

// File: tb/tb_approx_adder_pipe.sv
// tb_approx_adder_pipe: self-checking bench for approx_adder_pipe (default and 16/6 instances)
module tb_approx_adder_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, in_valid, in_ready, in_mode, out_valid, out_ready;
  logic [7:0] in_a, in_b;
  logic [8:0] out_sum;
  logic [15:0] ops_count;
  logic in_valid16, in_ready16, in_mode16, out_valid16, out_ready16;
  logic [15:0] in_a16, in_b16;
  logic [16:0] out_sum16;
  logic [15:0] ops_count16;
`ifdef APPROX_ERR_MON_EN
  logic [8:0] err_abs;
  logic [15:0] err_count;
  logic [16:0] err_abs16;
  logic [15:0] err_count16;
`endif
  approx_adder_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .ops_count(ops_count)
`ifdef APPROX_ERR_MON_EN
    , .err_abs(err_abs), .err_count(err_count)
`endif
  );
  approx_adder_pipe #(.WIDTH(16), .APPROX_BITS(6), .CNT_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16), .in_a(in_a16),
    .in_b(in_b16), .in_mode(in_mode16), .out_valid(out_valid16), .out_ready(out_ready16),
    .out_sum(out_sum16), .ops_count(ops_count16)
`ifdef APPROX_ERR_MON_EN
    , .err_abs(err_abs16), .err_count(err_count16)
`endif
  );
  typedef struct {
    bit mode;
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] sum;
    logic [8:0] err;
  } vec_t;
  int n_chk = 0, n_fail = 0;
  logic [31:0] q[$], qe[$], q16[$], qe16[$];
  int unsigned ops_m = 0, errc_m = 0, ops16_m = 0, errc16_m = 0;
  bit acc, acc16;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int unsigned ref_sum(input int unsigned a, input int unsigned b, input bit mode, input int ab);
    int unsigned lo, cy, p;
    if (mode) return a + b;
    lo = 0;
    cy = 0;
    for (int k = 0; k < ab / 2; k++) begin
      for (int j = 0; j < 2; j++) begin
        p = (a >> (2 * k + j)) & (b >> (2 * k + j)) & 1;
        lo |= (cy != 0 ? p : 1 - p) << (2 * k + j);
      end
      cy = (((a >> (2 * k)) & 3) == 3 || ((b >> (2 * k)) & 3) == 3 || cy != 0) ? 1 : 0;
    end
    return (((a >> ab) + (b >> ab) + cy) << ab) | lo;
  endfunction
  task automatic tick();
    int unsigned s, r;
    #1;
    acc = 0;
    acc16 = 0;
    if (rst_n) begin
      if (in_valid && in_ready) begin
        s = ref_sum(in_a, in_b, in_mode, 4);
        r = in_a + in_b;
        q.push_back(s);
        qe.push_back(s > r ? s - r : r - s);
        acc = 1;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("spurious_out", {31'b0, out_valid}, 0);
        else begin
          s = q.pop_front();
          r = qe.pop_front();
          check("out_sum", {23'b0, out_sum}, s);
`ifdef APPROX_ERR_MON_EN
          check("err_abs", {23'b0, err_abs}, r);
`endif
          if (ops_m != 65535) ops_m++;
          if (r != 0 && errc_m != 65535) errc_m++;
        end
      end
      if (in_valid16 && in_ready16) begin
        s = ref_sum(in_a16, in_b16, in_mode16, 6);
        r = in_a16 + in_b16;
        q16.push_back(s);
        qe16.push_back(s > r ? s - r : r - s);
        acc16 = 1;
      end
      if (out_valid16 && out_ready16) begin
        if (q16.size() == 0) check("spurious_out16", {31'b0, out_valid16}, 0);
        else begin
          s = q16.pop_front();
          r = qe16.pop_front();
          check("out_sum16", {15'b0, out_sum16}, s);
`ifdef APPROX_ERR_MON_EN
          check("err_abs16", {15'b0, err_abs16}, r);
`endif
          if (ops16_m != 65535) ops16_m++;
          if (r != 0 && errc16_m != 65535) errc16_m++;
        end
      end
    end
    @(negedge clk);
  endtask
  task automatic drain();
    for (int t = 0; t < 50 && (q.size() != 0 || q16.size() != 0); t++) tick();
    check("drain_q", q.size(), 0);
    check("drain_q16", q16.size(), 0);
  endtask
  initial begin
    vec_t tv[6];
    logic [8:0] held;
    int na, na16;
    bit all_rdy;
    logic [15:0] ops0;
    tv[0] = '{1'b0, 8'h00, 8'h00, 9'h00F, 9'd15};
    tv[1] = '{1'b0, 8'hFF, 8'h01, 9'h102, 9'd2};
    tv[2] = '{1'b1, 8'hFF, 8'h01, 9'h100, 9'd0};
    tv[3] = '{1'b0, 8'h0F, 8'h0F, 9'h01C, 9'd2};
    tv[4] = '{1'b0, 8'h80, 8'h80, 9'h10F, 9'd15};
    tv[5] = '{1'b0, 8'h55, 8'hAA, 9'h0FF, 9'd0};
    rst_n = 0; in_valid = 0; in_mode = 0; in_a = 0; in_b = 0; out_ready = 1;
    in_valid16 = 0; in_mode16 = 0; in_a16 = 0; in_b16 = 0; out_ready16 = 1;
    @(negedge clk);
    tick();
    tick();
    check("rst_out_valid", {31'b0, out_valid}, 0);
    check("rst_out_sum", {23'b0, out_sum}, 0);
    check("rst_ops_count", {16'b0, ops_count}, 0);
`ifdef APPROX_ERR_MON_EN
    check("rst_err_count", {16'b0, err_count}, 0);
`endif
    rst_n = 1;
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 1);
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      in_valid = 1; in_mode = tv[i].mode; in_a = tv[i].a; in_b = tv[i].b;
      tick();
      in_valid = 0;
      check($sformatf("tv%0d_early", i), {31'b0, out_valid}, 0);
      tick();
      check($sformatf("tv%0d_valid", i), {31'b0, out_valid}, 1);
      check($sformatf("tv%0d_sum", i), {23'b0, out_sum}, {23'b0, tv[i].sum});
`ifdef APPROX_ERR_MON_EN
      check($sformatf("tv%0d_err", i), {23'b0, err_abs}, {23'b0, tv[i].err});
`endif
      tick();
      check($sformatf("tv%0d_ops", i), {16'b0, ops_count}, i + 1);
`ifdef APPROX_ERR_MON_EN
      check($sformatf("tv%0d_errc", i), {16'b0, err_count}, errc_m);
`endif
    end
    ops0 = ops_count;
    all_rdy = 1;
    in_valid = 1;
    for (int i = 0; i < 16; i++) begin
      in_a = 8'($urandom); in_b = 8'($urandom); in_mode = 1'($urandom);
      tick();
      if (!acc) all_rdy = 0;
    end
    in_valid = 0;
    tick(); tick(); tick();
    check("stream_in_ready", {31'b0, all_rdy}, 1);
    check("stream_ops", {16'b0, ops_count}, {16'b0, ops0} + 16);
    check("stream_q", q.size(), 0);
    out_ready = 0; in_valid = 1; na = 0;
    in_a = 8'($urandom); in_b = 8'($urandom); in_mode = 1'($urandom);
    held = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (acc) begin
        na++;
        in_a = 8'($urandom); in_b = 8'($urandom); in_mode = 1'($urandom);
      end
      if (i == 2) held = out_sum;
    end
    check("bp_accepts", na, 2);
    check("bp_in_ready", {31'b0, in_ready}, 0);
    check("bp_out_valid", {31'b0, out_valid}, 1);
    check("bp_hold", {23'b0, out_sum}, {23'b0, held});
    out_ready = 1; in_valid = 0;
    drain();
    out_ready = 0; in_valid = 1;
    tick();
    in_a = 8'($urandom); in_b = 8'($urandom);
    tick();
    in_valid = 0; rst_n = 0;
    tick();
    q.delete(); qe.delete(); q16.delete(); qe16.delete();
    ops_m = 0; errc_m = 0; ops16_m = 0; errc16_m = 0;
    rst_n = 1;
    check("midrst_out_valid", {31'b0, out_valid}, 0);
    check("midrst_ops", {16'b0, ops_count}, 0);
`ifdef APPROX_ERR_MON_EN
    check("midrst_errc", {16'b0, err_count}, 0);
`endif
    out_ready = 1;
    for (int i = 0; i < 4; i++) tick();
    check("midrst_no_stale", {31'b0, out_valid}, 0);
    na = 0; na16 = 0;
    in_a = 8'($urandom); in_b = 8'($urandom); in_mode = 1'($urandom);
    in_a16 = 16'($urandom); in_b16 = 16'($urandom); in_mode16 = 1'($urandom);
    for (int t = 0; t < 6000 && (na < 1000 || na16 < 1000); t++) begin
      in_valid = na < 1000 && $urandom_range(4) != 0;
      in_valid16 = na16 < 1000 && $urandom_range(4) != 0;
      out_ready = $urandom_range(9) < 7;
      out_ready16 = $urandom_range(9) < 6;
      tick();
      if (acc) begin
        na++;
        in_a = 8'($urandom); in_b = 8'($urandom); in_mode = 1'($urandom);
      end
      if (acc16) begin
        na16++;
        in_a16 = 16'($urandom); in_b16 = 16'($urandom); in_mode16 = 1'($urandom);
      end
    end
    in_valid = 0; in_valid16 = 0; out_ready = 1; out_ready16 = 1;
    check("rand_sent", na, 1000);
    check("rand_sent16", na16, 1000);
    drain();
    check("rand_ops", {16'b0, ops_count}, ops_m);
    check("rand_ops16", {16'b0, ops_count16}, ops16_m);
`ifdef APPROX_ERR_MON_EN
    check("rand_errc", {16'b0, err_count}, errc_m);
    check("rand_errc16", {16'b0, err_count16}, errc16_m);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
